// File: rtl/quidditch_pkg.sv
// Shared constants and encodings for the quidditch game sequencer:
// field geometry, fixed player columns, hoop centres and state encodings.
package quidditch_pkg;

    typedef logic [9:0] coord_t;

    localparam int SCORE_W = 4;

    localparam coord_t FIELD_Y_MIN = 10'd35;
    localparam coord_t FIELD_Y_MAX = 10'd514;
    localparam coord_t FIELD_X_MIN = 10'd144;
    localparam coord_t FIELD_X_MAX = 10'd783;

    localparam coord_t TEAM1_X  = 10'd300;
    localparam coord_t TEAM2_X  = 10'd600;
    localparam coord_t CENTRE_X = 10'd463;
    localparam coord_t CENTRE_Y = 10'd275;

    // Hoops 0..2 sit on team2's side (team1 scores), hoops 3..5 on team1's side.
    localparam int NUM_HOOPS      = 6;
    localparam int HOOPS_PER_TEAM = 3;
    localparam coord_t HOOP_X [NUM_HOOPS] = '{10'd700, 10'd700, 10'd700, 10'd200, 10'd200, 10'd200};
    localparam coord_t HOOP_Y [NUM_HOOPS] = '{10'd100, 10'd220, 10'd330, 10'd210, 10'd330, 10'd450};

    typedef enum logic [1:0] {
        GS_SERVE = 2'd0,
        GS_PLAY  = 2'd1,
        GS_OVER  = 2'd2
    } game_state_t;

    typedef enum logic [1:0] {
        SEQ_WAIT    = 2'd0,
        SEQ_PLAYERS = 2'd1,
        SEQ_BALL    = 2'd2,
        SEQ_CHECK   = 2'd3
    } seq_state_t;

endpackage

// File: rtl/circle_hit.sv
// Combinational point-in-circle test: hit when the squared distance from
// (px,py) to the centre (cx,cy) is strictly below r2.
module circle_hit (
    input  logic [9:0]  cx,
    input  logic [9:0]  cy,
    input  logic [9:0]  px,
    input  logic [9:0]  py,
    input  logic [21:0] r2,
    output logic        hit
);

    logic signed [10:0] dx;
    logic signed [10:0] dy;
    logic signed [21:0] dx_ext;
    logic signed [21:0] dy_ext;
    logic signed [21:0] dx_sq;
    logic signed [21:0] dy_sq;
    logic        [21:0] dist_sq;

    assign dx     = $signed({1'b0, px}) - $signed({1'b0, cx});
    assign dy     = $signed({1'b0, py}) - $signed({1'b0, cy});
    assign dx_ext = {{11{dx[10]}}, dx};
    assign dy_ext = {{11{dy[10]}}, dy};
    // Squares of 11-bit differences stay below 2^21, so the sum never overflows.
    assign dx_sq   = dx_ext * dx_ext;
    assign dy_sq   = dy_ext * dy_ext;
    assign dist_sq = $unsigned(dx_sq) + $unsigned(dy_sq);
    assign hit     = (dist_sq < r2);

endmodule

// File: rtl/quidditch_game_ctrl.sv
// Per-frame game sequencer: moves players and ball, bounces, scores goals,
// and only touches its outputs in the three cycles after a ver_sync fall.
module quidditch_game_ctrl
    import quidditch_pkg::*;
#(
    parameter int PLAYER_SPEED  = 4,
    parameter int BALL_SPEED    = 3,
    parameter int SERVE_FRAMES  = 60,
    parameter int WIN_SCORE     = 9,
    parameter int PLAYER_RADIUS = 25,
    parameter int BALL_RADIUS   = 5,
    parameter int GOAL_RADIUS   = 40
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ver_sync,
    input  logic               t1_up,
    input  logic               t1_dn,
    input  logic               t2_up,
    input  logic               t2_dn,
    input  logic               start,
    output logic [9:0]         team1_ver_pos,
    output logic [9:0]         team2_ver_pos,
    output logic [9:0]         ball_x,
    output logic [9:0]         ball_y,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic [1:0]         game_state
);

    localparam int SERVE_W = $clog2(SERVE_FRAMES + 1);
    localparam logic [SERVE_W-1:0] SERVE_LAST = SERVE_W'(SERVE_FRAMES - 1);
    localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);

    localparam coord_t PLAYER_Y_LO = 10'(FIELD_Y_MIN + PLAYER_RADIUS);
    localparam coord_t PLAYER_Y_HI = 10'(FIELD_Y_MAX - PLAYER_RADIUS);
    localparam coord_t BALL_X_LO   = 10'(FIELD_X_MIN + BALL_RADIUS);
    localparam coord_t BALL_X_HI   = 10'(FIELD_X_MAX - BALL_RADIUS);
    localparam coord_t BALL_Y_LO   = 10'(FIELD_Y_MIN + BALL_RADIUS);
    localparam coord_t BALL_Y_HI   = 10'(FIELD_Y_MAX - BALL_RADIUS);

    localparam logic signed [10:0] P_STEP  = 11'(PLAYER_SPEED);
    localparam logic signed [10:0] B_STEP  = 11'(BALL_SPEED);
    localparam logic signed [10:0] HIT_BOX = 11'(PLAYER_RADIUS + BALL_RADIUS);
    localparam logic [21:0]        GOAL_R2 = 22'((GOAL_RADIUS - 2) * (GOAL_RADIUS - 2));

    // Signed 11-bit add keeps a step past zero from wrapping before the clamp.
    function automatic coord_t add_clamp(input coord_t v, input logic signed [10:0] delta,
                                         input coord_t lo, input coord_t hi);
        logic signed [10:0] s;
        s = $signed({1'b0, v}) + delta;
        if (s < $signed({1'b0, lo})) begin
            s = $signed({1'b0, lo});
        end else if (s > $signed({1'b0, hi})) begin
            s = $signed({1'b0, hi});
        end
        return s[9:0];
    endfunction

    function automatic logic signed [10:0] btn_delta(input logic up, input logic dn);
        if (up && !dn) begin
            return -P_STEP;
        end
        if (dn && !up) begin
            return P_STEP;
        end
        return '0;
    endfunction

    function automatic logic within_box(input coord_t a, input coord_t b);
        logic signed [10:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        if (d[10]) begin
            d = -d;
        end
        return (d <= HIT_BOX);
    endfunction

    logic [4:0]         in_meta_reg;
    logic [4:0]         in_sync_reg;
    logic               start_prev_reg;
    logic               ver_sync_reg;
    seq_state_t         seq_state_reg,  seq_state_next;
    game_state_t        game_state_reg, game_state_next;
    coord_t             team1_pos_reg,  team1_pos_next;
    coord_t             team2_pos_reg,  team2_pos_next;
    coord_t             ball_x_reg,     ball_x_next;
    coord_t             ball_y_reg,     ball_y_next;
    logic               dir_x_reg,      dir_x_next;
    logic               dir_y_reg,      dir_y_next;
    logic [SCORE_W-1:0] score1_reg,     score1_next;
    logic [SCORE_W-1:0] score2_reg,     score2_next;
    logic [SERVE_W-1:0] serve_cnt_reg,  serve_cnt_next;
    logic               start_req_reg,  start_req_next;

    logic t1_up_s, t1_dn_s, t2_up_s, t2_dn_s, start_s;
    logic tick, start_edge;
    logic goal1, goal2, hit1, hit2;
    logic [SCORE_W-1:0] score1_inc, score2_inc;
    logic [NUM_HOOPS-1:0] hoop_hit;

    assign t1_up_s    = in_sync_reg[0];
    assign t1_dn_s    = in_sync_reg[1];
    assign t2_up_s    = in_sync_reg[2];
    assign t2_dn_s    = in_sync_reg[3];
    assign start_s    = in_sync_reg[4];
    assign tick       = ver_sync_reg & ~ver_sync;
    assign start_edge = start_s & ~start_prev_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_HOOPS; gi++) begin : g_hoop
            circle_hit u_hoop (
                .cx  (HOOP_X[gi]),
                .cy  (HOOP_Y[gi]),
                .px  (ball_x_reg),
                .py  (ball_y_reg),
                .r2  (GOAL_R2),
                .hit (hoop_hit[gi])
            );
        end
    endgenerate

    assign goal1      = |hoop_hit[HOOPS_PER_TEAM-1:0];
    assign goal2      = |hoop_hit[NUM_HOOPS-1:HOOPS_PER_TEAM];
    assign hit1       = within_box(ball_x_reg, TEAM1_X) && within_box(ball_y_reg, team1_pos_reg);
    assign hit2       = within_box(ball_x_reg, TEAM2_X) && within_box(ball_y_reg, team2_pos_reg);
    assign score1_inc = score1_reg + SCORE_W'(1);
    assign score2_inc = score2_reg + SCORE_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_meta_reg    <= '0;
            in_sync_reg    <= '0;
            start_prev_reg <= 1'b0;
            ver_sync_reg   <= 1'b0;
            seq_state_reg  <= SEQ_WAIT;
            game_state_reg <= GS_SERVE;
            team1_pos_reg  <= CENTRE_Y;
            team2_pos_reg  <= CENTRE_Y;
            ball_x_reg     <= CENTRE_X;
            ball_y_reg     <= CENTRE_Y;
            dir_x_reg      <= 1'b1;
            dir_y_reg      <= 1'b1;
            score1_reg     <= '0;
            score2_reg     <= '0;
            serve_cnt_reg  <= '0;
            start_req_reg  <= 1'b0;
        end else begin
            in_meta_reg    <= {start, t2_dn, t2_up, t1_dn, t1_up};
            in_sync_reg    <= in_meta_reg;
            start_prev_reg <= start_s;
            ver_sync_reg   <= ver_sync;
            seq_state_reg  <= seq_state_next;
            game_state_reg <= game_state_next;
            team1_pos_reg  <= team1_pos_next;
            team2_pos_reg  <= team2_pos_next;
            ball_x_reg     <= ball_x_next;
            ball_y_reg     <= ball_y_next;
            dir_x_reg      <= dir_x_next;
            dir_y_reg      <= dir_y_next;
            score1_reg     <= score1_next;
            score2_reg     <= score2_next;
            serve_cnt_reg  <= serve_cnt_next;
            start_req_reg  <= start_req_next;
        end
    end

    always_comb begin
        seq_state_next  = seq_state_reg;
        game_state_next = game_state_reg;
        team1_pos_next  = team1_pos_reg;
        team2_pos_next  = team2_pos_reg;
        ball_x_next     = ball_x_reg;
        ball_y_next     = ball_y_reg;
        dir_x_next      = dir_x_reg;
        dir_y_next      = dir_y_reg;
        score1_next     = score1_reg;
        score2_next     = score2_reg;
        serve_cnt_next  = serve_cnt_reg;
        start_req_next  = start_req_reg;

        // A restart request is latched and applied in CHECK so outputs stay frame-aligned.
        if (start_edge && (game_state_reg == GS_OVER)) begin
            start_req_next = 1'b1;
        end

        case (seq_state_reg)
            SEQ_WAIT: begin
                if (tick) begin
                    seq_state_next = SEQ_PLAYERS;
                end
            end
            SEQ_PLAYERS: begin
                seq_state_next = SEQ_BALL;
                if (game_state_reg != GS_OVER) begin
                    team1_pos_next = add_clamp(team1_pos_reg, btn_delta(t1_up_s, t1_dn_s),
                                               PLAYER_Y_LO, PLAYER_Y_HI);
                    team2_pos_next = add_clamp(team2_pos_reg, btn_delta(t2_up_s, t2_dn_s),
                                               PLAYER_Y_LO, PLAYER_Y_HI);
                end
            end
            SEQ_BALL: begin
                seq_state_next = SEQ_CHECK;
                if (game_state_reg == GS_PLAY) begin
                    ball_x_next = add_clamp(ball_x_reg, dir_x_reg ? B_STEP : -B_STEP,
                                            BALL_X_LO, BALL_X_HI);
                    ball_y_next = add_clamp(ball_y_reg, dir_y_reg ? B_STEP : -B_STEP,
                                            BALL_Y_LO, BALL_Y_HI);
                end
            end
            SEQ_CHECK: begin
                seq_state_next = SEQ_WAIT;
                case (game_state_reg)
                    GS_SERVE: begin
                        if (serve_cnt_reg == SERVE_LAST) begin
                            game_state_next = GS_PLAY;
                            serve_cnt_next  = '0;
                        end else begin
                            serve_cnt_next = serve_cnt_reg + SERVE_W'(1);
                        end
                    end
                    GS_PLAY: begin
                        if (goal1 || goal2) begin
                            ball_x_next     = CENTRE_X;
                            ball_y_next     = CENTRE_Y;
                            serve_cnt_next  = '0;
                            dir_x_next      = goal1;
                            dir_y_next      = 1'b1;
                            game_state_next = GS_SERVE;
                            if (goal1) begin
                                score1_next = score1_inc;
                                if (score1_inc == WIN_VAL) begin
                                    game_state_next = GS_OVER;
                                end
                            end else begin
                                score2_next = score2_inc;
                                if (score2_inc == WIN_VAL) begin
                                    game_state_next = GS_OVER;
                                end
                            end
                        end else begin
                            // Forced rather than toggled so a ball inside a player cannot oscillate.
                            if (hit1) begin
                                dir_x_next = 1'b1;
                            end else if (hit2) begin
                                dir_x_next = 1'b0;
                            end
                            if (ball_y_reg <= BALL_Y_LO) begin
                                dir_y_next = 1'b1;
                            end else if (ball_y_reg >= BALL_Y_HI) begin
                                dir_y_next = 1'b0;
                            end
                            if (ball_x_reg <= BALL_X_LO) begin
                                dir_x_next = 1'b1;
                            end else if (ball_x_reg >= BALL_X_HI) begin
                                dir_x_next = 1'b0;
                            end
                        end
                    end
                    GS_OVER: begin
                        if (start_req_reg) begin
                            start_req_next  = 1'b0;
                            score1_next     = '0;
                            score2_next     = '0;
                            ball_x_next     = CENTRE_X;
                            ball_y_next     = CENTRE_Y;
                            team1_pos_next  = CENTRE_Y;
                            team2_pos_next  = CENTRE_Y;
                            dir_x_next      = 1'b1;
                            dir_y_next      = 1'b1;
                            serve_cnt_next  = '0;
                            game_state_next = GS_SERVE;
                        end
                    end
                    default: begin
                        game_state_next = GS_SERVE;
                    end
                endcase
            end
            default: begin
                seq_state_next = SEQ_WAIT;
            end
        endcase
    end

    assign team1_ver_pos = team1_pos_reg;
    assign team2_ver_pos = team2_pos_reg;
    assign ball_x        = ball_x_reg;
    assign ball_y        = ball_y_reg;
    assign score1        = score1_reg;
    assign score2        = score2_reg;
    assign game_state    = game_state_reg;

endmodule

// File: doc/quidditch_game_ctrl.md
Name: quidditch_game_ctrl

Overview:
Per-frame game sequencer that produces every moving coordinate the VGA pixel generator draws. Each frame it updates both player positions from their buttons, advances the ball, bounces it off the field walls and the players, detects goals through the hoops, and keeps score. All updates happen while ver_sync is low, so the pixel generator always sees stable coordinates during the active region.

Parameters:
PLAYER_SPEED, 4, player vertical step in pixels per frame
BALL_SPEED, 3, ball step in pixels per frame on each axis
SERVE_FRAMES, 60, frames the ball is held at centre before play resumes
WIN_SCORE, 9, score that ends the game
PLAYER_RADIUS, 25, player circle radius
BALL_RADIUS, 5, ball radius
GOAL_RADIUS, 40, hoop radius

Ports:
clk  in  1  pixel clock, the same clock that drives the x/y counters
rst_n  in  1  asynchronous active-low reset
ver_sync  in  1  vertical sync from the VGA timing, same clock domain
t1_up, t1_dn, t2_up, t2_dn  in  1 each  level-sensitive player buttons, asynchronous
start  in  1  level input; a rising edge restarts the game after it ends
team1_ver_pos  out  10  team1 player centre y; x is fixed at 300
team2_ver_pos  out  10  team2 player centre y; x is fixed at 600
ball_x, ball_y  out  10 each  ball centre
score1, score2  out  4 each  team scores
game_state  out  2  0=SERVE, 1=PLAY, 2=OVER

Behaviour:
- Reset values: team1_ver_pos=team2_ver_pos=275, ball=(463,275), scores 0, game_state SERVE, serve counter 0, ball direction +x,+y, frame sequencer in WAIT.
- Input sync: buttons and start each pass through a 2-flop synchronizer. Start rising edge is detected after synchronization.
- Frame tick: one-cycle pulse when the registered ver_sync is 1 and the current ver_sync is 0 (falling edge).
- Frame sequencer: WAIT -(tick)-> PLAYERS -> BALL -> CHECK -> WAIT, one cycle per state. All outputs change only in PLAYERS, BALL or CHECK, so they are settled 3 cycles after the tick.
- Field bounds: Y 35..514, X 144..783.
- PLAYERS state:
  - up only: pos -= PLAYER_SPEED; down only: pos += PLAYER_SPEED; both or neither: hold.
  - Result is clamped to [60,489]. Compute in 11-bit signed so underflow cannot wrap.
  - Players move in every game_state except OVER.
- BALL state, PLAY only: each axis steps by BALL_SPEED in its current direction, then clamps to x [149,778], y [40,509].
- CHECK state, PLAY only, evaluated in priority order:
  1. Goal. Squared distance from the ball centre to a hoop centre < (GOAL_RADIUS-2)^2 = 1444.
     - Hoops (700,100), (700,220), (700,330): score1 += 1.
     - Hoops (200,210), (200,330), (200,450): score2 += 1.
     - Ball returns to centre, serve counter clears, state becomes SERVE. Serve direction is toward the team that conceded (-x if team1 conceded), y direction +.
     - If the new score equals WIN_SCORE, state becomes OVER instead of SERVE.
  2. Player hit. Box test |ball_x-300|<=30 and |ball_y-team1_ver_pos|<=30 forces dir_x=+. The same test against (600, team2_ver_pos) forces dir_x=-. Direction is forced, not toggled, so the ball cannot stick inside a player.
  3. Walls. ball_y<=40 sets dir_y=+; ball_y>=509 sets dir_y=-. ball_x<=149 sets dir_x=+; ball_x>=778 sets dir_x=-. Walls apply on the same frame as a player hit.
- Arithmetic widths: differences are 11-bit signed, squares are 22-bit unsigned.
- SERVE: ball held at (463,275). The counter increments each tick. When the counter reaches SERVE_FRAMES-1 on a tick, state becomes PLAY and the counter clears.
- OVER: ball and players frozen, scores held. A start edge clears scores, recentres the ball and players, and enters SERVE. Start edges outside OVER are ignored.
- Reset mid-frame: everything returns to reset values at once; no partial update survives.

Decomposition:
- Package quidditch_pkg holds:
  - field bounds and fixed player x (300, 600)
  - the six hoop centres as constant arrays
  - game_state encoding (SERVE/PLAY/OVER) and frame sequencer encoding (WAIT/PLAYERS/BALL/CHECK)
  - the score width
- Sub-module circle_hit: combinational squared-distance compare (cx, cy, px, py, r2 -> hit), instantiated six times for the hoops. The VGA pixel generator can later reuse it.

Test Plan:
- Reset, then 3 frame ticks with no buttons -> positions 275/275, ball (463,275), game_state 0.
- t1_up held 60 frames -> team1_ver_pos reaches 60 and holds at 60. t2_up and t2_dn held together -> team2 stays 275.
- 60 ticks in SERVE -> PLAY on the 60th tick. Next tick ball moves to (466,278).
- Force ball to (697,218) moving +x in PLAY -> on that frame score1=1, ball (463,275), SERVE, dir_x=+ (team2 conceded).
- Ball at y=508 with dir_y=+ -> clamped to 509, dir_y becomes -, next frame y=506.
- score1=8 and a team1 goal -> score1=9 and OVER. Frames then freeze everything. A start edge clears scores and enters SERVE.
